// File: rtl/multiples_fifo_ctrl_if.sv
// Signal bundle between multiples_fifo_ctrl, the upstream multiplier array,
// the multiples_fifo buffer ports and the downstream accumulator.
interface multiples_fifo_ctrl_if #(
    parameter int AW = 13,
    parameter int DW = 32,
    parameter int CW = 4
);
    // Both streams use valid/ready. A transfer happens on a rising edge where
    // valid and ready are both high. Valid never waits for ready, and ready
    // never depends combinationally on the valid of the same stream.
    logic          prod_valid;
    logic          prod_ready;
    logic [DW-1:0] prod_data;
    logic          prod_last;

    logic          fifo_write_enable;
    logic [AW-1:0] fifo_write_address;
    logic [DW-1:0] fifo_input_data;
    logic [AW-1:0] fifo_read_address;
    logic [DW-1:0] fifo_output_data;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    modport master (
        input  prod_valid, prod_data, prod_last, fifo_output_data, out_ready,
        output prod_ready, fifo_write_enable, fifo_write_address, fifo_input_data,
               fifo_read_address, out_valid, out_data, out_last, count, full, empty
    );

    modport slave (
        output prod_valid, prod_data, prod_last, fifo_output_data, out_ready,
        input  prod_ready, fifo_write_enable, fifo_write_address, fifo_input_data,
               fifo_read_address, out_valid, out_data, out_last, count, full, empty
    );
endinterface

// File: rtl/multiples_fifo_ctrl.sv
// Pointer/handshake controller for the 10-entry multiples_fifo product buffer.
// The buffer's write port is 1-based, and its read port is 0-based.
module multiples_fifo_ctrl #(
    parameter int DEPTH = 10,
    parameter int AW    = 13,
    parameter int DW    = 32,
    parameter int CW    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    multiples_fifo_ctrl_if.master bus
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] last_bits_q, last_bits_d;
    logic [DW-1:0]    rd_data;
    logic             full, empty, push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // rst_n gates ready so that nothing is accepted while reset is held.
    assign bus.prod_ready = ~full & rst_n;
    assign bus.out_valid  = ~empty & rst_n;

    assign push = bus.prod_valid & bus.prod_ready & ~flush;
    assign pop  = bus.out_valid & bus.out_ready & ~flush;

    assign bus.fifo_write_enable  = push;
    assign bus.fifo_input_data    = bus.prod_data;
    assign bus.fifo_write_address = AW'(wr_ptr_q) + AW'(1);
    assign bus.fifo_read_address  = AW'(rd_ptr_q);

    assign rd_data      = bus.fifo_output_data;
    assign bus.out_data = rd_data;
    assign bus.out_last = last_bits_q[rd_ptr_q];

    assign bus.count = count_q;
    assign bus.full  = full;
    assign bus.empty = empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        last_bits_d = last_bits_q;
        if (flush) begin
            // Buffer contents stay; they are unreachable once the pointers are zero.
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            last_bits_d = '0;
        end else begin
            if (push) begin
                last_bits_d[wr_ptr_q] = bus.prod_last;
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_bits_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            last_bits_q <= last_bits_d;
        end
    end
endmodule

// File: tb/tb_multiples_fifo_ctrl.sv
// Bench for multiples_fifo_ctrl: a behavioural 10-slot buffer, directed
// stimulus, and a scoreboard that pairs every accepted product with its pop.
module tb_multiples_fifo_ctrl;
    localparam int DEPTH = 10;
    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int CW    = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multiples_fifo_ctrl_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

    multiples_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    // Buffer model: 1-based write address, 0-based combinational read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.fifo_write_enable && bus.fifo_write_address >= 1 && bus.fifo_write_address <= DEPTH)
            mem[bus.fifo_write_address - 1] <= bus.fifo_input_data;
    end
    assign bus.fifo_output_data = (bus.fifo_read_address < DEPTH) ? mem[bus.fifo_read_address] : '0;

    // ---------------- scoreboard ----------------
    logic [DW:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected product for every accepted output.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (rst_n && bus.out_valid && bus.out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got data 0x%0h, expected no output", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", 64'(bus.out_data), 64'(e[DW-1:0]));
                check("sb_last", 64'(bus.out_last), 64'(e[DW]));
            end
        end
    end

    // Invariants: no write when full, no pop when empty.
    always @(negedge clk) begin
        if (rst_n && bus.fifo_write_enable)
            check("inv_push_full", 64'(bus.count == CW'(DEPTH)), 64'(0));
        if (rst_n && bus.out_valid && bus.out_ready && !flush)
            check("inv_pop_empty", 64'(bus.count == '0), 64'(0));
    end

    // ---------------- driver tasks ----------------
    // Inputs change #1 after a rising edge; drive() returns at the following
    // falling edge, where the caller samples combinational outputs.
    task automatic drive(input logic pv, input logic [DW-1:0] pd, input logic pl,
                         input logic ordy, input logic fl);
        bus.prod_valid = pv;
        bus.prod_data  = pd;
        bus.prod_last  = pl;
        bus.out_ready  = ordy;
        flush          = fl;
        @(negedge clk);
        if (rst_n && pv && bus.prod_ready && !fl)
            exp_q.push_back({pl, pd});
    endtask

    task automatic tick();
        @(posedge clk);
        if (flush) exp_q.delete();
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, '0, 1'b0, ordy, 1'b0);
            tick();
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.prod_valid = 1'b0;
        bus.prod_data  = '0;
        bus.prod_last  = 1'b0;
        bus.out_ready  = 1'b0;
        flush          = 1'b0;
        #2;
        check("rst_prod_ready", 64'(bus.prod_ready), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_wen", 64'(bus.fifo_write_enable), 64'(0));
        @(posedge clk);
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_prod_ready", 64'(bus.prod_ready), 64'(1));
        check("rel_empty", 64'(bus.empty), 64'(1));
        check("rel_full", 64'(bus.full), 64'(0));
        check("rel_waddr", 64'(bus.fifo_write_address), 64'(1));
        check("rel_raddr", 64'(bus.fifo_read_address), 64'(0));
        check("rel_count", 64'(bus.count), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        apply_reset();

        // Single write and visibility one edge later.
        drive(1'b1, 32'h3F80_0000, 1'b1, 1'b0, 1'b0);
        check("t1_wen", 64'(bus.fifo_write_enable), 64'(1));
        check("t1_waddr", 64'(bus.fifo_write_address), 64'(1));
        check("t1_no_bypass", 64'(bus.out_valid), 64'(0));
        tick();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("t1_out_valid", 64'(bus.out_valid), 64'(1));
        check("t1_out_data", 64'(bus.out_data), 64'h3F80_0000);
        check("t1_out_last", 64'(bus.out_last), 64'(1));
        check("t1_count", 64'(bus.count), 64'(1));
        tick();

        // Fill to full from a fresh reset.
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'(i + 1), 1'b0, 1'b0, 1'b0);
            check("t2_waddr", 64'(bus.fifo_write_address), 64'(i + 1));
            check("t2_wen", 64'(bus.fifo_write_enable), 64'(1));
            tick();
        end
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        check("t2_full", 64'(bus.full), 64'(1));
        check("t2_prod_ready", 64'(bus.prod_ready), 64'(0));
        check("t2_count", 64'(bus.count), 64'(10));
        check("t2_11th_wen", 64'(bus.fifo_write_enable), 64'(0));
        tick();

        // Drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
            check("t3_raddr", 64'(bus.fifo_read_address), 64'(i));
            check("t3_out_valid", 64'(bus.out_valid), 64'(1));
            tick();
            if (i == 0) check("t3_ready_rise", 64'(bus.prod_ready), 64'(1));
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("t3_empty", 64'(bus.empty), 64'(1));
        check("t3_out_valid_lo", 64'(bus.out_valid), 64'(0));
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0, 1'b0);
            check("t3_wrap_waddr", 64'(bus.fifo_write_address), 64'(i + 1));
            tick();
        end
        idle(3, 1'b1);
        check("t3_leftover", 64'(exp_q.size()), 64'(0));

        // Simultaneous push/pop at count 5.
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 1'(i % 3 == 2), 1'b1, 1'b0);
            check("t4_count", 64'(bus.count), 64'(5));
            check("t4_wen", 64'(bus.fifo_write_enable), 64'(1));
            tick();
        end
        idle(5, 1'b1);
        check("t4_leftover", 64'(exp_q.size()), 64'(0));
        check("t4_empty", 64'(bus.empty), 64'(1));

        // Flush at count 7 with a product offered.
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h3FF, 1'b1, 1'b1, 1'b1);
        check("t5_flush_wen", 64'(bus.fifo_write_enable), 64'(0));
        check("t5_pre_count", 64'(bus.count), 64'(7));
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("t5_count", 64'(bus.count), 64'(0));
        check("t5_waddr", 64'(bus.fifo_write_address), 64'(1));
        check("t5_raddr", 64'(bus.fifo_read_address), 64'(0));
        check("t5_out_last", 64'(bus.out_last), 64'(0));
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        // Asynchronous reset in the middle of an accepted write.
        drive(1'b1, 32'h4FF, 1'b0, 1'b1, 1'b0);
        check("t5_count4", 64'(bus.count), 64'(4));
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_ar_out_valid", 64'(bus.out_valid), 64'(0));
        check("t5_ar_wen", 64'(bus.fifo_write_enable), 64'(0));
        check("t5_ar_count", 64'(bus.count), 64'(0));
        exp_q.delete();
        apply_reset();

        // Row marker across the slot 9 -> slot 0 boundary.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h600 + 32'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle(8, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h700 + 32'(i), 1'(i == 3), 1'b0, 1'b0);
            check("t6_waddr", 64'(bus.fifo_write_address), 64'((i < 2) ? (i + 9) : (i - 1)));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
            check("t6_out_last", 64'(bus.out_last), 64'(i == 3));
            check("t6_raddr", 64'(bus.fifo_read_address), 64'((i < 2) ? (i + 8) : (i - 2)));
            tick();
        end
        idle(1, 1'b0);
        check("t6_leftover", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/multiples_fifo_ctrl.md
Name: multiples_fifo_ctrl

Overview:
Pointer and handshake controller that sits directly upstream of multiples_fifo, the 10-entry product buffer. It accepts the 32-bit product stream from the multiplier array with valid/ready, drives the buffer's write port using its 1-based write-address convention, and drives the 0-based read address. It presents buffered products, each with a row-end marker, to the downstream accumulator through a valid/ready interface. It also tracks occupancy and full/empty.

Parameters:
DEPTH, 10, number of buffer slots; must equal the buffer's address modulus
AW, 13, buffer address width
DW, 32, data width
CW, 4, occupancy counter width; must hold 0..DEPTH

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of pointers, occupancy and markers
prod_valid  input  1  upstream product valid
prod_ready  output  1  controller can accept a product
prod_data  input  DW  upstream product value
prod_last  input  1  product is the last one of a matrix row
fifo_write_enable  output  1  buffer write strobe
fifo_write_address  output  AW  buffer write address, 1-based: value k writes slot k-1
fifo_input_data  output  DW  buffer write data
fifo_read_address  output  AW  buffer read address, 0-based slot index
fifo_output_data  input  DW  buffer combinational read data
out_valid  output  1  product available downstream
out_ready  input  1  downstream accepts product
out_data  output  DW  product value to downstream
out_last  output  1  row-end marker of out_data
count  output  CW  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr = 0, rd_ptr = 0, count = 0, last_bits[DEPTH-1:0] = 0.
  - While rst_n is low: fifo_write_enable = 0, out_valid = 0, prod_ready = 0.
  - After release: prod_ready = 1, empty = 1, full = 0, fifo_write_address = 1, fifo_read_address = 0.
- Push:
  - push = prod_valid & prod_ready & ~flush.
  - prod_ready = ~full. This is registered state only; there is no combinational path from out_ready.
  - fifo_write_enable = push, fifo_input_data = prod_data, fifo_write_address = wr_ptr + 1. All three are combinational.
  - On the clock edge with push: last_bits[wr_ptr] <= prod_last; wr_ptr <= (wr_ptr == DEPTH-1) ? 0 : wr_ptr + 1.
  - Address value DEPTH therefore writes slot DEPTH-1. Address 0 is never driven.
- Pop:
  - pop = out_valid & out_ready & ~flush.
  - out_valid = ~empty.
  - fifo_read_address = rd_ptr, zero-extended to AW.
  - out_data = fifo_output_data, combinational pass-through.
  - out_last = last_bits[rd_ptr].
  - On pop: rd_ptr wraps DEPTH-1 -> 0.
- Occupancy:
  - push only: count + 1. Pop only: count - 1. Both or neither: count unchanged.
  - full and empty are decoded from count, not from pointer comparison.
- Latency:
  - A product pushed at edge N is visible on out_valid/out_data after edge N.
  - There is no same-cycle bypass when empty.
- Simultaneous push and pop:
  - Allowed when neither full nor empty.
  - When full, push is blocked by prod_ready = 0; pop proceeds, and prod_ready rises the next cycle.
  - When empty, pop is impossible (out_valid = 0); push proceeds.
- Wrap-around: pointers cycle 0..DEPTH-1 continuously; sequences longer than DEPTH preserve order.
- flush:
  - Highest priority after reset. In the flush cycle, fifo_write_enable = 0 and no pop is counted.
  - Next state: wr_ptr = rd_ptr = 0, count = 0, last_bits = 0.
  - Buffer contents are not cleared; they are unreachable until rewritten.
- Reset mid-stream: immediate return to reset state. A write in flight in that cycle is suppressed because the enable is forced low.
- Invariants:
  - A pop never occurs with count == 0.
  - A push never occurs with count == DEPTH.
  - The verification bench asserts both.

Test Plan:
- Reset and single write: after rst_n release, push 0x3F800000 with last=1 -> fifo_write_enable=1, fifo_write_address=1 that cycle. Next cycle: out_valid=1, out_data=0x3F800000, out_last=1, count=1.
- Fill to full: push 10 products 0x1..0xA with out_ready=0 -> write addresses 1..10. full=1 and prod_ready=0 after the 10th. An 11th prod_valid produces no write.
- Drain in order with wrap: from full, out_ready=1 for 10 cycles -> out_data 0x1..0xA, read addresses 0..9. Then empty=1, out_valid=0. Then push 3 more -> write addresses 1,2,3 (slots 0..2).
- Simultaneous push/pop: at count=5, hold prod_valid=out_ready=1 for 20 cycles -> count stays 5, output order equals input order, and pointers wrap at least twice.
- Flush and reset mid-stream: at count=7, assert flush with prod_valid=1 -> no write that cycle, next cycle count=0, write address=1, read address=0. Then with count=4, drop rst_n asynchronously -> out_valid and fifo_write_enable go 0 immediately and count=0.
- Row marker tracking: push a row of 4 products with last only on the 4th -> out_last=0,0,0,1 across the corresponding pops, including when the row straddles slot 9 -> slot 0.
